// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle of the UART transmit arbiter.
// The arbiter takes the master view; producers and the UART take the slave view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_accept;
    logic [NUM_REQ-1:0]   req_done;
    logic [NUM_REQ-1:0]   req_err;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 tx_done;

    modport master (
        input  req_valid, req_data, req_lock, tx_done,
        output req_accept, req_done, req_err, tx_en, tx_data
    );

    modport slave (
        output req_valid, req_data, req_lock, tx_done,
        input  req_accept, req_done, req_err, tx_en, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// with optional bus lock, per-requester completion routing and a transmit watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_arbiter_if.master        bus,
    output logic                     busy,
    output logic [2:0]               grant_id,
    output logic                     timeout_err
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, DONE} state_e;

    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RR_INIT   = 3'(NUM_REQ - 1);
    localparam logic [3:0]       NUM_REQ_W = 4'(NUM_REQ);

    state_e             state_q, state_d;
    logic [2:0]         rr_q, rr_d;
    logic [2:0]         grant_q, grant_d;
    logic               lock_valid_q, lock_valid_d;
    logic [2:0]         lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] accept_q, accept_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;

    logic [7:0] valid_ext;
    logic [7:0] lock_ext;
    logic [7:0] eligible;
    logic       locked;
    logic       found;
    logic [2:0] winner;
    logic [3:0] cand;
    logic [7:0] data_sel;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
        onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) onehot[i] = (idx == 3'(i));
    endfunction

    // A live lock restricts eligibility to its owner; search starts just after rr.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        valid_ext = 8'(bus.req_valid);
        lock_ext  = 8'(bus.req_lock);
        locked    = lock_valid_q && lock_ext[lock_owner_q];
        eligible  = locked ? (valid_ext & (8'd1 << lock_owner_q)) : valid_ext;
        found     = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
            if (!found && eligible[cand[2:0]]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) data_sel = bus.req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        lock_valid_d  = lock_valid_q;
        lock_owner_d  = lock_owner_q;
        wd_d          = wd_q;
        tx_en_d       = 1'b0;
        tx_data_d     = tx_data_q;
        accept_d      = '0;
        done_d        = '0;
        err_d         = '0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (!locked) lock_valid_d = 1'b0;
                if (found) begin
                    grant_d   = winner;
                    tx_data_d = data_sel;
                    tx_en_d   = 1'b1;
                    accept_d  = onehot(winner);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                rr_d         = grant_q;
                wd_d         = '0;
                lock_valid_d = lock_ext[grant_q];
                lock_owner_d = grant_q;
                state_d      = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    done_d  = onehot(grant_q);
                    state_d = DONE;
                end else if (wd_q == WD_LAST) begin
                    done_d        = onehot(grant_q);
                    err_d         = onehot(grant_q);
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_q          <= RR_INIT;
            grant_q       <= '0;
            lock_valid_q  <= 1'b0;
            lock_owner_q  <= '0;
            wd_q          <= '0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= '0;
            accept_q      <= '0;
            done_q        <= '0;
            err_q         <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            grant_q       <= grant_d;
            lock_valid_q  <= lock_valid_d;
            lock_owner_q  <= lock_owner_d;
            wd_q          <= wd_d;
            tx_en_q       <= tx_en_d;
            tx_data_q     <= tx_data_d;
            accept_q      <= accept_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.tx_en      = tx_en_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.req_accept = accept_q;
    assign bus.req_done   = done_q;
    assign bus.req_err    = err_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;
    assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-port byte sources, an auto-responding UART
// model, and queues of expected grants and completions checked as the DUT produces them.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 20;

    typedef struct {
        int         port;
        logic [7:0] data;
    } tx_exp_t;

    typedef struct {
        int port;
        bit err;
    } done_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [2:0] grant_id;
    logic       timeout_err;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    logic [7:0] src0[$];
    logic [7:0] src1[$];
    tx_exp_t    exp_q[$];
    done_exp_t  done_q[$];

    int         n_checks = 0;
    int         n_pass   = 0;
    bit         lock0 = 1'b0;
    bit         lock1 = 1'b0;
    bit         uart_auto = 1'b1;
    int         uart_delay = 3;
    int         uart_cnt = 0;
    bit         expect_abort = 1'b0;
    logic [7:0] cur_byte = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic drive_inputs();
        bus.req_valid[0]   = (src0.size() > 0);
        bus.req_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
        bus.req_valid[1]   = (src1.size() > 0);
        bus.req_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
        bus.req_lock       = {lock1, lock0};
    endtask

    function automatic logic [31:0] bit_of(input int port);
        return 32'(1) << port;
    endfunction

    // One clock: sample after the edge, score outputs, run the UART model, update requesters.
    task automatic tick();
        tx_exp_t   e;
        done_exp_t d;
        @(posedge clk);
        #1;
        bus.tx_done = 1'b0;

        if (bus.req_accept[0] === 1'b1 && src0.size() > 0) void'(src0.pop_front());
        if (bus.req_accept[1] === 1'b1 && src1.size() > 0) void'(src1.pop_front());

        if (bus.tx_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("tx_en_unexpected", 32'(bus.tx_en), 0);
            end else begin
                e = exp_q.pop_front();
                check("grant_id", 32'(grant_id), 32'(e.port));
                check("tx_data", 32'(bus.tx_data), 32'(e.data));
                check("req_accept", 32'(bus.req_accept), bit_of(e.port));
                d.port = e.port;
                d.err  = expect_abort;
                done_q.push_back(d);
                cur_byte = e.data;
            end
        end else if (bus.req_accept !== '0 && !reset) begin
            check("accept_without_tx_en", 32'(bus.req_accept), 0);
        end

        if (bus.req_done !== '0 || bus.req_err !== '0) begin
            if (done_q.size() == 0) begin
                check("req_done_unexpected", 32'(bus.req_done), 0);
            end else begin
                d = done_q.pop_front();
                check("req_done", 32'(bus.req_done), bit_of(d.port));
                check("req_err", 32'(bus.req_err), d.err ? bit_of(d.port) : 32'(0));
            end
        end

        if (bus.tx_en === 1'b1 && uart_auto) begin
            uart_cnt = uart_delay;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                check("tx_data_stable", 32'(bus.tx_data), 32'(cur_byte));
                bus.tx_done = 1'b1;
            end
        end

        drive_inputs();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && done_q.size() == 0 && busy === 1'b0 &&
                uart_cnt == 0 && bus.tx_done === 1'b0) return;
        end
        check("wait_idle_budget", 32'(exp_q.size() + done_q.size()) + 32'(busy), 0);
    endtask

    task automatic push_exp(input int port, input logic [7:0] data);
        tx_exp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.tx_done = 1'b0;
        drive_inputs();
        do_reset();
        tick();
        check("rst_tx_en", 32'(bus.tx_en), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_req_accept", 32'(bus.req_accept), 0);
        check("rst_req_done", 32'(bus.req_done), 0);
        check("rst_req_err", 32'(bus.req_err), 0);

        // Single request: tx_en one cycle after the request, done one cycle after tx_done.
        src0.push_back(8'hA5);
        push_exp(0, 8'hA5);
        drive_inputs();
        tick();
        check("single_tx_en_lat", 32'(bus.tx_en), 1);
        check("single_busy", 32'(busy), 1);
        for (int i = 0; i < 10 && bus.tx_done !== 1'b1; i++) tick();
        tick();
        check("single_done_lat", 32'(bus.req_done), 1);
        tick();
        check("single_busy_after", 32'(busy), 0);

        // Contention from a fresh reset: ports alternate starting with port 0.
        do_reset();
        src0.push_back(8'h11); src0.push_back(8'h11);
        src1.push_back(8'h22); src1.push_back(8'h22);
        push_exp(0, 8'h11); push_exp(1, 8'h22);
        push_exp(0, 8'h11); push_exp(1, 8'h22);
        drive_inputs();
        wait_idle(200);

        // Lock: port 1 keeps the bus for three bytes while port 0 waits.
        lock1 = 1'b1;
        src1.push_back(8'h31); src1.push_back(8'h32); src1.push_back(8'h33);
        push_exp(1, 8'h31); push_exp(1, 8'h32); push_exp(1, 8'h33);
        drive_inputs();
        tick();
        src0.push_back(8'h44);
        drive_inputs();
        wait_idle(200);
        repeat (5) tick();
        check("lock_quiet_busy", 32'(busy), 0);
        check("lock_quiet_grant", 32'(grant_id), 1);
        lock1 = 1'b0;
        push_exp(0, 8'h44);
        drive_inputs();
        wait_idle(100);
        check("lock_release_grant", 32'(grant_id), 0);

        // Spurious tx_done in IDLE and LOAD is ignored.
        uart_auto = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        check("spur_idle_busy", 32'(busy), 0);
        src0.push_back(8'hB7);
        push_exp(0, 8'hB7);
        drive_inputs();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b1;
        tick();
        check("spur_load_busy", 32'(busy), 1);
        check("spur_load_done", 32'(bus.req_done), 0);
        repeat (3) tick();
        check("spur_wait_done", 32'(bus.req_done), 0);
        bus.tx_done = 1'b1;
        tick();
        check("spur_real_done", 32'(bus.req_done), 1);
        tick();

        // Watchdog abort on the 20th WAIT_DONE cycle.
        check("timeout_err_pre", 32'(timeout_err), 0);
        expect_abort = 1'b1;
        src0.push_back(8'hC3);
        push_exp(0, 8'hC3);
        drive_inputs();
        tick();
        repeat (TIMEOUT) tick();
        check("timeout_not_yet", 32'(bus.req_done), 0);
        check("timeout_busy", 32'(busy), 1);
        tick();
        check("timeout_done", 32'(bus.req_done), 1);
        check("timeout_err_set", 32'(timeout_err), 1);
        repeat (3) tick();
        expect_abort = 1'b0;
        check("timeout_err_sticky", 32'(timeout_err), 1);

        // Reset during WAIT_DONE drops the transfer silently.
        src1.push_back(8'hD1);
        push_exp(1, 8'hD1);
        drive_inputs();
        tick();
        tick();
        check("midrst_busy_before", 32'(busy), 1);
        reset = 1'b1;
        tick();
        done_q.delete();
        check("midrst_tx_en", 32'(bus.tx_en), 0);
        check("midrst_tx_data", 32'(bus.tx_data), 0);
        check("midrst_grant_id", 32'(grant_id), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_timeout_err", 32'(timeout_err), 0);
        check("midrst_req_done", 32'(bus.req_done), 0);
        reset = 1'b0;
        repeat (3) tick();
        uart_auto = 1'b1;
        src0.push_back(8'hE0);
        src1.push_back(8'hE1);
        push_exp(0, 8'hE0);
        push_exp(1, 8'hE1);
        drive_inputs();
        wait_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
